// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: iterative, one bit per cycle, fixed latency.
// Divide datapath is built only when MULDIV_DIVIDE_EN is defined.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            wb_en,
  output logic            illegal
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [5:0]      cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_a_q, neg_a_d;
  logic            neg_b_q, neg_b_d;
  logic            ill_q, ill_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [4:0]      rd_lat_q, rd_lat_d;
  logic [4:0]      rd_out_q, rd_out_d;

  logic            a_sgn, b_sgn;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_bad;

  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   res_fin;

`ifdef MULDIV_DIVIDE_EN
  logic [XLEN:0]   shl;
  logic            sub_ok;
  logic [XLEN-1:0] sub;
  logic            b_zero;
  logic [XLEN-1:0] quo_s, rem_s;

  assign div_bad = 1'b0;
`else
  assign div_bad = funct3[2];
`endif

  // Operands are reduced to magnitudes; signs are reapplied at the end.
  always_comb begin
    a_sgn = (funct3 == 3'b001) || (funct3 == 3'b010) ||
            (funct3 == 3'b100) || (funct3 == 3'b110);
    b_sgn = (funct3 == 3'b001) || (funct3 == 3'b100) ||
            (funct3 == 3'b110);
    a_neg = a_sgn & rs1_val[XLEN-1];
    b_neg = b_sgn & rs2_val[XLEN-1];
    a_mag = a_neg ? -rs1_val : rs1_val;
    b_mag = b_neg ? -rs2_val : rs2_val;
  end

  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    step_hi = mul_sum[XLEN:1];
    step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
`ifdef MULDIV_DIVIDE_EN
    shl    = {hi_q, lo_q[XLEN-1]};
    sub_ok = shl >= {1'b0, b_q};
    sub    = shl[XLEN-1:0] - b_q;
    if (op_q[2]) begin
      step_hi = sub_ok ? sub : shl[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], sub_ok};
    end
`endif
  end

  always_comb begin
    prod   = {step_hi, step_lo};
    prod_s = (neg_a_q ^ neg_b_q) ? -prod : prod;
`ifdef MULDIV_DIVIDE_EN
    // Divide by zero keeps the all-ones quotient and raw dividend.
    b_zero = (b_q == '0);
    quo_s  = ((neg_a_q ^ neg_b_q) && !b_zero) ? -step_lo : step_lo;
    rem_s  = neg_a_q ? -step_hi : step_hi;
`endif
    case (op_q)
      3'b000:                 res_fin = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res_fin = prod_s[2*XLEN-1:XLEN];
`ifdef MULDIV_DIVIDE_EN
      3'b100, 3'b101:         res_fin = quo_s;
      3'b110, 3'b111:         res_fin = rem_s;
`endif
      default:                res_fin = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_CALC;
      S_CALC: if (ill_q || cnt_q == 6'd1) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    illegal = done & ill_q;
    wb_en   = done & (rd_out_q != 5'd0) & ~ill_q;
    result  = res_q;
    rd_out  = rd_out_q;
  end

  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    ill_d    = ill_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    res_d    = res_q;
    rd_lat_d = rd_lat_q;
    rd_out_d = rd_out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d     = funct3;
          neg_a_d  = a_neg;
          neg_b_d  = b_neg;
          ill_d    = div_bad;
          hi_d     = '0;
          lo_d     = a_mag;
          b_d      = b_mag;
          cnt_d    = 6'd32;
          rd_lat_d = rd_in;
        end
      end
      S_CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - 6'd1;
        if (ill_q) begin
          res_d    = '0;
          rd_out_d = rd_lat_q;
        end else if (cnt_q == 6'd1) begin
          res_d    = res_fin;
          rd_out_d = rd_lat_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      ill_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      res_q    <= '0;
      rd_lat_q <= '0;
      rd_out_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      ill_q    <= ill_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      res_q    <= res_d;
      rd_lat_q <= rd_lat_d;
      rd_out_q <= rd_out_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: random and directed RV32M ops
// checked against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        wb_en;
  logic        illegal;

  muldiv_unit #(.XLEN(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd_in   (rd_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .rd_out  (rd_out),
    .wb_en   (wb_en),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wb;
    logic        ill;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] a64, b64, p;
    logic [31:0] q, r;
    a64 = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
    b64 = (f == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p   = a64 * b64;
    if (f == 3'd0) return p[31:0];
    if (!f[2]) return p[63:32];
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!f[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return f[1] ? r : q;
  endfunction

  task automatic issue(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    exp_t e;
    int   g = 0;
    @(negedge clk);
    while (busy && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (busy) begin
      chk("issue_timeout_busy", {31'd0, busy}, 32'd0);
      return;
    end
    funct3  = f;
    rs1_val = a;
    rs2_val = b;
    rd_in   = rd;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
`ifdef MULDIV_DIVIDE_EN
    e.ill = 1'b0;
`else
    e.ill = f[2];
`endif
    e.res = e.ill ? 32'd0 : ref_model(f, a, b);
    e.rd  = rd;
    e.wb  = (rd != 5'd0) && !e.ill;
    e.cyc = cyc + (e.ill ? 1 : 32);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", {31'd0, done}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
          chk("wb_en", {31'd0, wb_en}, {31'd0, e.wb});
          chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          last_res = e.res;
          last_rd  = e.rd;
        end
      end else begin
        chk("hold_result", result, last_res);
        chk("hold_rd_out", {27'd0, rd_out}, {27'd0, last_rd});
        chk("idle_wb_en", {31'd0, wb_en}, 32'd0);
        chk("idle_illegal", {31'd0, illegal}, 32'd0);
      end
    end
  end

  function automatic logic [31:0] pick(input int zero_bias);
    logic [31:0] v;
    case ($urandom_range(0, 5 + zero_bias))
      0: v = 32'h8000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'd1;
      3, 4: v = $urandom;
      5: v = $urandom_range(0, 255);
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  initial begin
    int g;
    rst     = 1'b1;
    start   = 1'b0;
    funct3  = '0;
    rs1_val = '0;
    rs2_val = '0;
    rd_in   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd_out", {27'd0, rd_out}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    rst = 1'b0;

    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    issue(3'd5, 32'd100, 32'd0, 5'd4);
    issue(3'd7, 32'd100, 32'd0, 5'd6);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd9);
    issue(3'd0, 32'd9, 32'd9, 5'd0);

    // A start while busy must not disturb the running op.
    issue(3'd0, 32'd11, 32'd13, 5'd10);
    repeat (5) @(negedge clk);
    funct3  = 3'd3;
    rs1_val = 32'hDEAD_BEEF;
    rs2_val = 32'h1234_5678;
    rd_in   = 5'd20;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Asynchronous reset mid-calculation aborts the op.
    issue(3'd0, 32'd1234, 32'd5678, 5'd11);
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_rd_out", {27'd0, rd_out}, 32'd0);
    sb.delete();
    last_res = '0;
    last_rd  = '0;
    @(negedge clk);
    rst = 1'b0;
    issue(3'd0, 32'd3, 32'd4, 5'd12);

    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), pick(0), pick(2),
            5'($urandom_range(0, 31)));
    end

    g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
